// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the integer pipeline: branch funct3 codes, writeback
// select encodings and the EX/MEM squash state.
package rv_pipe_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;
  localparam logic [1:0] WB_SEL_CSR = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } squash_state_e;

  // BEQ/BNE run the ALU as XOR, BLT/BGE as SLT, so ZERO carries the compare.
  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic       zero,
                                       input logic       sltu_bit);
    logic cond;
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = ~zero;
      F3_BGE:  cond = zero;
      F3_BLTU: cond = sltu_bit;
      F3_BGEU: cond = ~sltu_bit;
      default: cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/ex_mem_branch_stage_branch_resolve.sv
// Combinational branch/jump resolution: decides whether control transfers,
// where to, and whether the destination is misaligned.
module branch_resolve
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            branch,
  input  logic            jal,
  input  logic            jalr,
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic            sltu_bit,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] br_target,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic unused_alu_lsb;

  assign unused_alu_lsb = alu_result[0];

  always_comb begin
    taken  = 1'b0;
    target = br_target;
    if (jal) begin
      taken = 1'b1;
    end else if (jalr) begin
      taken  = 1'b1;
      // JALR clears bit 0 of the computed address
      target = {alu_result[XLEN-1:1], 1'b0};
    end else if (branch) begin
      taken = branch_cond(funct3, zero, sltu_bit);
    end
  end

  assign misalign = target[1];

endmodule

// File: rtl/ex_mem_branch_stage.sv
// EX/MEM pipeline register with branch/jump resolution, registered fetch
// redirect and squashing of wrong-path instructions that follow a redirect.
module ex_mem_branch_stage
  import rv_pipe_pkg::*;
#(
  parameter int KILL_CYCLES = 1,
  parameter int XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] alu_result,
  input  logic            zero,
  input  logic            sltu_bit,
  input  logic            branch,
  input  logic            jal,
  input  logic            jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [4:0]      rd_addr,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      mem_size,
  input  logic [XLEN-1:0] store_data,
  input  logic [1:0]      wb_sel,
  output logic            mem_valid,
  output logic [XLEN-1:0] mem_result,
  output logic [4:0]      mem_rd_addr,
  output logic            mem_reg_write,
  output logic            mem_mem_read,
  output logic            mem_mem_write,
  output logic [2:0]      mem_size_out,
  output logic [XLEN-1:0] mem_store_data,
  output logic [1:0]      mem_wb_sel,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            misalign_exc
);

  localparam logic [1:0] KILL_LOAD = 2'(KILL_CYCLES);

  logic            taken;
  logic [XLEN-1:0] target;
  logic            misalign;
  logic            live;
  logic            live_taken;

  squash_state_e   state_q, state_d;
  logic [1:0]      kill_cnt_q, kill_cnt_d;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic [2:0]      mem_size_q, mem_size_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misalign_q, misalign_d;

  branch_resolve #(.XLEN(XLEN)) u_resolve (
    .branch     (branch),
    .jal        (jal),
    .jalr       (jalr),
    .funct3     (funct3),
    .zero       (zero),
    .sltu_bit   (sltu_bit),
    .alu_result (alu_result),
    .br_target  (br_target),
    .taken      (taken),
    .target     (target),
    .misalign   (misalign)
  );

  assign live       = ex_valid & (state_q == ST_RUN);
  assign live_taken = live & taken;

  // Next-state and next-slot logic; priority is flush, then stall, then update.
  always_comb begin
    state_d       = state_q;
    kill_cnt_d    = kill_cnt_q;
    valid_d       = valid_q;
    result_d      = result_q;
    rd_addr_d     = rd_addr_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_size_d    = mem_size_q;
    store_data_d  = store_data_q;
    wb_sel_d      = wb_sel_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;
    misalign_d    = misalign_q;

    // Data fields follow EX whenever the pipe advances, live or not.
    if (!stall) begin
      result_d     = (jal | jalr) ? pc_plus4 : alu_result;
      rd_addr_d    = rd_addr;
      mem_size_d   = mem_size;
      store_data_d = store_data;
      wb_sel_d     = wb_sel;
    end

    if (flush) begin
      state_d     = ST_RUN;
      kill_cnt_d  = 2'd0;
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      redirect_d  = 1'b0;
      misalign_d  = 1'b0;
    end else if (stall) begin
      redirect_d = 1'b0;
      misalign_d = 1'b0;
    end else begin
      valid_d     = live;
      reg_write_d = live & reg_write & ~(taken & misalign);
      mem_read_d  = live & mem_read;
      mem_write_d = live & mem_write;
      redirect_d  = live_taken & ~misalign;
      misalign_d  = live_taken & misalign;
      if (live_taken) begin
        redirect_pc_d = target;
      end

      case (state_q)
        ST_RUN: begin
          if (live_taken) begin
            state_d    = ST_KILL;
            kill_cnt_d = KILL_LOAD;
          end
        end
        ST_KILL: begin
          // Only real instructions consume a squash slot.
          if (ex_valid) begin
            kill_cnt_d = kill_cnt_q - 2'd1;
            if (kill_cnt_q == 2'd1) begin
              state_d = ST_RUN;
            end
          end
        end
        default: begin
          state_d    = ST_RUN;
          kill_cnt_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      kill_cnt_q    <= 2'd0;
      valid_q       <= 1'b0;
      result_q      <= '0;
      rd_addr_q     <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_size_q    <= '0;
      store_data_q  <= '0;
      wb_sel_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      kill_cnt_q    <= kill_cnt_d;
      valid_q       <= valid_d;
      result_q      <= result_d;
      rd_addr_q     <= rd_addr_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_size_q    <= mem_size_d;
      store_data_q  <= store_data_d;
      wb_sel_q      <= wb_sel_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  assign mem_valid      = valid_q;
  assign mem_result     = result_q;
  assign mem_rd_addr    = rd_addr_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign mem_size_out   = mem_size_q;
  assign mem_store_data = store_data_q;
  assign mem_wb_sel     = wb_sel_q;
  assign redirect       = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign misalign_exc   = misalign_q;

endmodule

// File: tb/tb_ex_mem_branch_stage.sv
// Bench for ex_mem_branch_stage: directed scenarios plus random traffic, all
// compared against a slot-level reference model of the EX/MEM stage.
module tb_ex_mem_branch_stage;

  localparam int XLEN  = 32;
  localparam int KILLS = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            stall, flush, ex_valid;
  logic [XLEN-1:0] alu_result;
  logic            zero, sltu_bit, branch, jal, jalr;
  logic [2:0]      funct3;
  logic [XLEN-1:0] br_target, pc_plus4;
  logic [4:0]      rd_addr;
  logic            reg_write, mem_read, mem_write;
  logic [2:0]      mem_size;
  logic [XLEN-1:0] store_data;
  logic [1:0]      wb_sel;
  logic            mem_valid;
  logic [XLEN-1:0] mem_result;
  logic [4:0]      mem_rd_addr;
  logic            mem_reg_write, mem_mem_read, mem_mem_write;
  logic [2:0]      mem_size_out;
  logic [XLEN-1:0] mem_store_data;
  logic [1:0]      mem_wb_sel;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            misalign_exc;

  int checks = 0;
  int errors = 0;

  // Reference model: expected MEM slot plus number of EX instructions still to squash.
  logic            e_valid, e_regw, e_mread, e_mwrite, e_redirect, e_mis;
  logic [XLEN-1:0] e_result, e_sdata, e_rpc;
  logic [4:0]      e_rd;
  logic [2:0]      e_size;
  logic [1:0]      e_wbsel;
  int              squash_left;

  always #5 clk = ~clk;

  ex_mem_branch_stage #(.KILL_CYCLES(KILLS), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .alu_result(alu_result), .zero(zero), .sltu_bit(sltu_bit), .branch(branch),
    .jal(jal), .jalr(jalr), .funct3(funct3), .br_target(br_target),
    .pc_plus4(pc_plus4), .rd_addr(rd_addr), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .store_data(store_data), .wb_sel(wb_sel), .mem_valid(mem_valid),
    .mem_result(mem_result), .mem_rd_addr(mem_rd_addr),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_size_out(mem_size_out),
    .mem_store_data(mem_store_data), .mem_wb_sel(mem_wb_sel),
    .redirect(redirect), .redirect_pc(redirect_pc), .misalign_exc(misalign_exc)
  );

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] obs,
                             input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic branchTaken(input logic [2:0] f3, input logic z, input logic lt);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return !z;
      3'b101:  return z;
      3'b110:  return lt;
      3'b111:  return !lt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic modelReset();
    e_valid = 0; e_regw = 0; e_mread = 0; e_mwrite = 0; e_redirect = 0; e_mis = 0;
    e_result = 0; e_sdata = 0; e_rpc = 0; e_rd = 0; e_size = 0; e_wbsel = 0;
    squash_left = 0;
  endtask

  task automatic modelStep();
    logic            live, tk, bad;
    logic [XLEN-1:0] tgt;
    if (!stall) begin
      e_result = (jal || jalr) ? pc_plus4 : alu_result;
      e_rd = rd_addr; e_size = mem_size; e_sdata = store_data; e_wbsel = wb_sel;
    end
    if (flush) begin
      e_valid = 0; e_regw = 0; e_mread = 0; e_mwrite = 0;
      e_redirect = 0; e_mis = 0; squash_left = 0;
    end else if (stall) begin
      e_redirect = 0; e_mis = 0;
    end else begin
      live = ex_valid && (squash_left == 0);
      tk   = jal || jalr || (branch && branchTaken(funct3, zero, sltu_bit));
      tgt  = jalr ? (alu_result & ~32'd1) : br_target;
      bad  = live && tk && tgt[1];
      e_valid    = live;
      e_mread    = live && mem_read;
      e_mwrite   = live && mem_write;
      e_regw     = live && reg_write && !bad;
      e_redirect = live && tk && !tgt[1];
      e_mis      = bad;
      if (live && tk) begin
        e_rpc = tgt;
        squash_left = KILLS;
      end else if (squash_left > 0 && ex_valid) begin
        squash_left--;
      end
    end
  endtask

  task automatic compareAll(input string ctx);
    checkOutput({ctx, ".valid"},    mem_valid,      e_valid);
    checkOutput({ctx, ".result"},   mem_result,     e_result);
    checkOutput({ctx, ".rd"},       mem_rd_addr,    e_rd);
    checkOutput({ctx, ".regw"},     mem_reg_write,  e_regw);
    checkOutput({ctx, ".mread"},    mem_mem_read,   e_mread);
    checkOutput({ctx, ".mwrite"},   mem_mem_write,  e_mwrite);
    checkOutput({ctx, ".size"},     mem_size_out,   e_size);
    checkOutput({ctx, ".sdata"},    mem_store_data, e_sdata);
    checkOutput({ctx, ".wbsel"},    mem_wb_sel,     e_wbsel);
    checkOutput({ctx, ".redirect"}, redirect,       e_redirect);
    checkOutput({ctx, ".rpc"},      redirect_pc,    e_rpc);
    checkOutput({ctx, ".misalign"}, misalign_exc,   e_mis);
  endtask

  task automatic setIdle();
    stall = 0; flush = 0; ex_valid = 0; alu_result = 0; zero = 0; sltu_bit = 0;
    branch = 0; jal = 0; jalr = 0; funct3 = 0; br_target = 0; pc_plus4 = 0;
    rd_addr = 0; reg_write = 0; mem_read = 0; mem_write = 0; mem_size = 0;
    store_data = 0; wb_sel = 0;
  endtask

  task automatic setAdd(input logic [XLEN-1:0] res, input logic [4:0] rd);
    setIdle();
    ex_valid = 1; alu_result = res; rd_addr = rd; reg_write = 1;
  endtask

  task automatic setBranch(input logic [2:0] f3, input logic z, input logic lt,
                           input logic [XLEN-1:0] tgt);
    setIdle();
    ex_valid = 1; branch = 1; funct3 = f3; zero = z; sltu_bit = lt; br_target = tgt;
  endtask

  // One clock: DUT and model both advance on the edge, compared 1 ns later.
  task automatic applyStimulus(input string ctx);
    @(posedge clk);
    modelStep();
    #1;
    compareAll(ctx);
  endtask

  task automatic applyReset(input string ctx);
    #2;
    rst_n = 0;
    #1;
    modelReset();
    compareAll(ctx);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drainFillers(input string ctx);
    for (int i = 0; i < KILLS; i++) begin
      setAdd(32'h10 + i, 5'd9);
      applyStimulus(ctx);
      checkOutput({ctx, ".bubble"}, mem_valid, 1'b0);
    end
  endtask

  initial begin
    setIdle();
    rst_n = 0;
    #1;
    modelReset();
    compareAll("por");
    @(negedge clk);
    rst_n = 1;

    setAdd(32'h7, 5'd5);
    applyStimulus("add");
    checkOutput("add_valid", mem_valid, 1);
    checkOutput("add_result", mem_result, 32'h7);
    checkOutput("add_rd", mem_rd_addr, 5'd5);
    checkOutput("add_redirect", redirect, 0);

    setBranch(3'b000, 1, 0, 32'h100);
    applyStimulus("beq");
    checkOutput("beq_redirect", redirect, 1);
    checkOutput("beq_rpc", redirect_pc, 32'h100);
    setAdd(32'h11, 5'd3);
    applyStimulus("beq_sq1");
    checkOutput("beq_sq1_valid", mem_valid, 0);
    checkOutput("beq_sq1_regw", mem_reg_write, 0);
    checkOutput("beq_sq1_redirect", redirect, 0);
    applyStimulus("beq_sq2");
    checkOutput("beq_sq2_valid", mem_valid, 0);
    setAdd(32'h22, 5'd4);
    applyStimulus("beq_after");
    checkOutput("beq_after_valid", mem_valid, 1);
    checkOutput("beq_after_regw", mem_reg_write, 1);

    setBranch(3'b110, 0, 0, 32'h200);
    applyStimulus("bltu");
    checkOutput("bltu_redirect", redirect, 0);
    setBranch(3'b111, 0, 0, 32'h204);
    applyStimulus("bgeu");
    checkOutput("bgeu_redirect", redirect, 1);
    drainFillers("bgeu_drain");
    setBranch(3'b010, 1, 1, 32'h208);
    applyStimulus("f3_010");
    checkOutput("f3_010_redirect", redirect, 0);

    setIdle(); ex_valid = 1; jalr = 1; alu_result = 32'h203; pc_plus4 = 32'h48;
    rd_addr = 5'd1; reg_write = 1;
    applyStimulus("jalr_mis");
    checkOutput("jalr_mis_rpc", redirect_pc, 32'h202);
    checkOutput("jalr_mis_exc", misalign_exc, 1);
    checkOutput("jalr_mis_redirect", redirect, 0);
    checkOutput("jalr_mis_regw", mem_reg_write, 0);
    drainFillers("jalr_mis_drain");
    setIdle(); ex_valid = 1; jalr = 1; alu_result = 32'h201; pc_plus4 = 32'h48;
    rd_addr = 5'd1; reg_write = 1;
    applyStimulus("jalr_ok");
    checkOutput("jalr_ok_rpc", redirect_pc, 32'h200);
    checkOutput("jalr_ok_result", mem_result, 32'h48);
    checkOutput("jalr_ok_redirect", redirect, 1);
    drainFillers("jalr_ok_drain");

    setBranch(3'b001, 0, 0, 32'h340);
    applyStimulus("stall_br");
    checkOutput("stall_br_redirect", redirect, 1);
    setAdd(32'h55, 5'd6);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall_hold");
      checkOutput("stall_hold_redirect", redirect, 0);
      checkOutput("stall_hold_valid", mem_valid, 1);
    end
    stall = 0;
    drainFillers("stall_drain");
    setAdd(32'h66, 5'd7);
    applyStimulus("stall_after");
    checkOutput("stall_after_valid", mem_valid, 1);

    setBranch(3'b101, 1, 0, 32'h400);
    applyStimulus("rst_br");
    setAdd(32'h77, 5'd8);
    applyStimulus("rst_sq");
    applyReset("rst_mid_kill");
    setAdd(32'h88, 5'd10);
    applyStimulus("rst_after");
    checkOutput("rst_after_valid", mem_valid, 1);

    setBranch(3'b000, 1, 0, 32'h500);
    applyStimulus("flush_br");
    setAdd(32'h99, 5'd11);
    flush = 1;
    applyStimulus("flush");
    checkOutput("flush_valid", mem_valid, 0);
    flush = 0;
    applyStimulus("flush_after");
    checkOutput("flush_after_valid", mem_valid, 1);

    // Random traffic: mixed ALU ops, memory ops, branches and jumps.
    for (int n = 0; n < 600; n++) begin
      int kind;
      setIdle();
      kind = $urandom_range(0, 7);
      ex_valid   = ($urandom_range(0, 7) != 0);
      alu_result = $urandom;
      br_target  = $urandom;
      pc_plus4   = $urandom;
      store_data = $urandom;
      rd_addr    = 5'($urandom);
      mem_size   = 3'($urandom);
      wb_sel     = 2'($urandom);
      funct3     = 3'($urandom);
      zero       = 1'($urandom);
      sltu_bit   = 1'($urandom);
      reg_write  = 1'($urandom);
      case (kind)
        4:       branch = 1;
        5:       jal = 1;
        6:       jalr = 1;
        7:       begin mem_read = 1'($urandom); mem_write = !mem_read; end
        default: ;
      endcase
      stall = ($urandom_range(0, 9) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) applyReset("rnd_reset");
      else applyStimulus("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_branch_stage.md
Name: ex_mem_branch_stage

Overview:
- EX/MEM pipeline register directly downstream of the integer ALU.
- Captures ALU RESULT and control into the MEM stage, and resolves conditional branches and JAL/JALR from ALU flags ZERO and SLTU_BIT.
- Issues a registered PC redirect to the fetch stage.
- Squashes wrong-path instructions that reach EX before the redirect takes effect.

Parameters:
- KILL_CYCLES, 1: number of EX instructions squashed after a redirect issues (1..3).
- XLEN, 32: datapath width.

Ports:
- CLK  in  1  pipeline clock.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  hazard unit: hold every register, counter and output.
- FLUSH  in  1  hazard unit: invalidate the MEM slot and clear squash state.
- EX_VALID  in  1  instruction in EX is real.
- ALU_RESULT  in  XLEN  ALU RESULT.
- ZERO  in  1  ALU ZERO flag.
- SLTU_BIT  in  1  ALU SLTU_BIT.
- BRANCH  in  1  conditional branch in EX.
- JAL  in  1  JAL in EX.
- JALR  in  1  JALR in EX.
- FUNCT3  in  3  branch type.
- BR_TARGET  in  XLEN  PC+imm from EX adder (branches, JAL).
- PC_PLUS4  in  XLEN  link value.
- RD_ADDR  in  5  destination register.
- REG_WRITE  in  1  writeback enable.
- MEM_READ  in  1  load.
- MEM_WRITE  in  1  store.
- MEM_SIZE  in  3  load/store funct3.
- STORE_DATA  in  XLEN  rs2 value.
- WB_SEL  in  2  writeback mux select.
- MEM_VALID  out  1  MEM slot holds a live instruction.
- MEM_RESULT  out  XLEN  ALU_RESULT, or PC_PLUS4 for JAL/JALR.
- MEM_RD_ADDR  out  5  registered RD_ADDR.
- MEM_REG_WRITE  out  1  registered REG_WRITE, gated by validity.
- MEM_MEM_READ  out  1  registered MEM_READ, gated by validity.
- MEM_MEM_WRITE  out  1  registered MEM_WRITE, gated by validity.
- MEM_SIZE_OUT  out  3  registered MEM_SIZE.
- MEM_STORE_DATA  out  XLEN  registered STORE_DATA.
- MEM_WB_SEL  out  2  registered WB_SEL.
- REDIRECT  out  1  one-cycle pulse: fetch must load REDIRECT_PC.
- REDIRECT_PC  out  XLEN  redirect target.
- MISALIGN_EXC  out  1  one-cycle pulse: taken target has bit1 set.

Behaviour:
- Reset (async, RESET=0):
  - MEM_VALID, MEM_REG_WRITE, MEM_MEM_READ, MEM_MEM_WRITE, REDIRECT, MISALIGN_EXC = 0.
  - All data outputs = 0.
  - State = RUN, kill counter = 0.
  - Reset mid-squash abandons the squash.
- Latency: every output is registered, one cycle after the EX inputs.
- Effective valid: live = EX_VALID & (state==RUN).
- Branch condition (FUNCT3), ALU configured upstream:
  - 000 BEQ: XOR op, taken = ZERO.
  - 001 BNE: XOR op, taken = ~ZERO.
  - 100 BLT: SLT op, taken = ~ZERO.
  - 101 BGE: SLT op, taken = ZERO.
  - 110 BLTU: taken = SLTU_BIT.
  - 111 BGEU: taken = ~SLTU_BIT.
  - 010/011: never taken.
- Targets:
  - JAL and branches use BR_TARGET.
  - JALR uses {ALU_RESULT[XLEN-1:1],1'b0}.
  - JAL/JALR are always taken, and MEM_RESULT = PC_PLUS4.
- Taken with live=1:
  - If target[1]==1: MISALIGN_EXC=1, REDIRECT=0, MEM_REG_WRITE=0, and state still enters KILL.
  - Otherwise: REDIRECT=1, REDIRECT_PC=target.
- FSM:
  - RUN: live taken -> KILL with counter=KILL_CYCLES.
  - KILL: each non-stalled cycle with EX_VALID=1 decrements the counter and writes a bubble (MEM_VALID=0, all enables 0). Counter reaching 0 -> RUN. Branches in KILL are ignored.
- STALL=1: all registers hold their value. REDIRECT and MISALIGN_EXC drop to 0 after one cycle; they never repeat while held.
- FLUSH=1 (priority over STALL): MEM_VALID and all enables = 0, state -> RUN, no redirect.
- Non-live slots: MEM_REG_WRITE, MEM_MEM_READ, MEM_MEM_WRITE are forced to 0. Data fields may still load.
- Simultaneous RESET and anything: reset wins. Then FLUSH, then STALL, then normal update.

Decomposition:
- Shared package rv_pipe_pkg:
  - FUNCT3 branch constants (BEQ..BGEU).
  - WB_SEL encodings.
  - RUN/KILL state encoding.
- One sub-module, branch_resolve: combinational taken/target/misalign from FUNCT3, flags, JAL, JALR.
- Registers and FSM stay in the top module.

Test Plan:
- Reset release, then an ADD (ALU_RESULT=0x00000007, RD=5, REG_WRITE=1) -> next cycle MEM_VALID=1, MEM_RESULT=7, MEM_RD_ADDR=5, REDIRECT=0.
- BEQ with ZERO=1, BR_TARGET=0x00000100 -> REDIRECT pulse with REDIRECT_PC=0x100. The following EX instruction (REG_WRITE=1) produces MEM_VALID=0, MEM_REG_WRITE=0. The one after passes normally.
- BLTU with SLTU_BIT=0 -> no redirect. BGEU with SLTU_BIT=0 -> redirect. FUNCT3=010 -> never redirects.
- JALR with ALU_RESULT=0x00000203, PC_PLUS4=0x00000048 -> REDIRECT_PC=0x202 with MISALIGN_EXC=1, REDIRECT=0. With ALU_RESULT=0x00000201 -> REDIRECT_PC=0x200, MEM_RESULT=0x48.
- Taken branch followed by STALL=1 for 3 cycles -> REDIRECT high exactly 1 cycle, MEM outputs frozen, squash counter resumes after the stall.
- RESET asserted during KILL with KILL_CYCLES=2 -> all outputs 0 immediately. After release, the first instruction is not squashed.
